instr_fetch_unit: RTL and testbench

//  Front end of the single-cycle/pipelined RV32I core: owns the fetch PC, issues word reads to instruction memory

---
 rtl/instr_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch front end.
// Owns the fetch PC and issues word reads to instruction memory under a credit limit.
// Returned words are buffered in a small FIFO and presented to the decoder as {instr, pc}.
// Taken-branch/jump redirects restart fetch and squash every wrong-path word still in flight.

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    // instruction memory request port
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,

    // instruction memory response port
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,

    // decoder side
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,

    // branch/jump redirect
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    // AW addresses the FIFO storage; CW holds any count from 0 up to 2*DEPTH-1,
    // which covers fifo_cnt + out_cnt without overflow.
    localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CW      = AW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);

    // fetch and response program counters
    logic [31:0]   r_fetchPc;
    logic [31:0]   r_rspPc;

    // FIFO occupancy, outstanding reads and reads still to be squashed
    logic [CW-1:0] r_fifoCnt;
    logic [CW-1:0] r_outCnt;
    logic [CW-1:0] r_discardCnt;

    // FIFO pointers and storage
    logic [AW-1:0] r_rdPtr;
    logic [AW-1:0] r_wrPtr;
    logic [31:0]   r_memInstr [DEPTH];
    logic [31:0]   r_memPc    [DEPTH];

    // combinational helpers
    logic [CW-1:0] w_creditSum;
    logic          w_reqValid;
    logic          w_reqFire;
    logic          w_instrValid;
    logic          w_pop;
    logic          w_rspIn;
    logic          w_rspDrop;
    logic          w_push;
    logic [31:0]   w_redirectPc;
    logic [CW-1:0] w_rspInCnt;
    logic [CW-1:0] w_reqFireCnt;
    logic [CW-1:0] w_pushCnt;
    logic [CW-1:0] w_popCnt;

    // Every outstanding read owns a FIFO slot, so a request is only allowed while
    // buffered plus in-flight words leave room; discarded reads still hold their slot
    // until the memory returns them.
    assign w_creditSum  = r_fifoCnt + r_outCnt;
    assign w_reqValid   = rst_n & ~redirect_valid & (w_creditSum < DEPTH_C);
    assign w_reqFire    = w_reqValid & imem_req_ready;

    assign w_instrValid = rst_n & (r_fifoCnt != '0) & ~redirect_valid;
    assign w_pop        = w_instrValid & instr_ready;

    // A response is squashed while older wrong-path reads remain, and always in a
    // redirect cycle because the whole in-flight set is being abandoned.
    assign w_rspIn      = rst_n & imem_rsp_valid;
    assign w_rspDrop    = (r_discardCnt != '0);
    assign w_push       = w_rspIn & ~w_rspDrop & ~redirect_valid;

    assign w_redirectPc = redirect_pc & ~32'h0000_0003;

    assign w_rspInCnt   = {{(CW-1){1'b0}}, w_rspIn};
    assign w_reqFireCnt = {{(CW-1){1'b0}}, w_reqFire};
    assign w_pushCnt    = {{(CW-1){1'b0}}, w_push};
    assign w_popCnt     = {{(CW-1){1'b0}}, w_pop};

    // While reset is held the outputs show the reset PC and zero data rather than stale FIFO contents.
    assign imem_req_valid = w_reqValid;
    assign imem_req_addr  = rst_n ? r_fetchPc : RESET_PC;
    assign instr_valid    = w_instrValid;
    assign instr          = rst_n ? r_memInstr[r_rdPtr] : 32'h0000_0000;
    assign instr_pc       = rst_n ? r_memPc[r_rdPtr]    : RESET_PC;

    // Control state: PCs, counters and pointers; redirect overrides all normal activity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetchPc    <= RESET_PC;
            r_rspPc      <= RESET_PC;
            r_fifoCnt    <= '0;
            r_outCnt     <= '0;
            r_discardCnt <= '0;
            r_rdPtr      <= '0;
            r_wrPtr      <= '0;
        end else if (redirect_valid) begin
            r_fetchPc    <= w_redirectPc;
            r_rspPc      <= w_redirectPc;
            r_fifoCnt    <= '0;
            r_rdPtr      <= '0;
            r_wrPtr      <= '0;
            r_outCnt     <= r_outCnt - w_rspInCnt;
            r_discardCnt <= r_outCnt - w_rspInCnt;
        end else begin
            if (w_reqFire) begin
                r_fetchPc <= r_fetchPc + 32'd4;
            end
            r_outCnt <= r_outCnt + w_reqFireCnt - w_rspInCnt;
            if (w_rspIn) begin
                if (w_rspDrop) begin
                    r_discardCnt <= r_discardCnt - {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    r_rspPc <= r_rspPc + 32'd4;
                end
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            r_fifoCnt <= r_fifoCnt + w_pushCnt - w_popCnt;
        end
    end

    // FIFO storage write; contents need no reset since the count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memInstr[r_wrPtr] <= imem_rsp_data;
            r_memPc[r_wrPtr]    <= r_rspPc;
        end
    end

    // Structural invariants of the credit scheme.
    a_noOverflow : assert property (@(posedge clk) disable iff (!rst_n)
        w_push |-> (r_fifoCnt < DEPTH_C));
    a_rspExpected : assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (r_outCnt != '0));
    a_creditBound : assert property (@(posedge clk) disable iff (!rst_n)
        w_creditSum <= DEPTH_C);
    a_discardBound : assert property (@(posedge clk) disable iff (!rst_n)
        r_discardCnt <= r_outCnt);
    a_pcDistance : assert property (@(posedge clk) disable iff (!rst_n)
        (r_fetchPc - r_rspPc) == (32'(r_outCnt - r_discardCnt) << 2));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the fetch front end.

module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    // free-running core clock
    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;
    int cyc = 0;

    // model: next fetch address, in-flight reads (address + squash flag), buffered words
    logic [31:0] mFetchPc = RESET_PC;
    logic [31:0] mInAddr[$];
    bit          mInDrop[$];
    logic [31:0] mFifoInstr[$];
    logic [31:0] mFifoPc[$];
    bit          expReqValid;
    bit          expInstrValid;

    // behavioural instruction memory: accepted addresses with their due cycle
    logic [31:0] memQAddr[$];
    int          memQDue[$];
    int          lastDue = -1;

    // values sampled from the DUT in the most recent cycle
    bit          sReqValid;
    bit          sInstrValid;
    logic [31:0] sReqAddr;
    logic [31:0] sInstrPc;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5EED_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // compares every DUT output against the model for the current cycle
    task automatic checkOutput();
        if (!rst_n) begin
            expReqValid   = 1'b0;
            expInstrValid = 1'b0;
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_req_addr", imem_req_addr, RESET_PC);
            check("rst_instr_valid", 32'(instr_valid), 32'd0);
            check("rst_instr", instr, 32'h0);
            check("rst_instr_pc", instr_pc, RESET_PC);
        end else begin
            expReqValid   = !redirect_valid && ((mFifoPc.size() + mInAddr.size()) < DEPTH);
            expInstrValid = !redirect_valid && (mFifoPc.size() != 0);
            check("req_valid", 32'(imem_req_valid), 32'(expReqValid));
            check("req_addr", imem_req_addr, mFetchPc);
            check("instr_valid", 32'(instr_valid), 32'(expInstrValid));
            if (expInstrValid) begin
                check("instr", instr, mFifoInstr[0]);
                check("instr_pc", instr_pc, mFifoPc[0]);
            end
        end
    endtask

    // advances the model by one clock edge
    task automatic updateModel(input bit instrReady, input bit reqReady, input bit redir,
                               input logic [31:0] target);
        logic [31:0] a;
        bit          d;
        if (!rst_n) begin
            mFetchPc = RESET_PC;
            mInAddr.delete();
            mInDrop.delete();
            mFifoInstr.delete();
            mFifoPc.delete();
        end else if (redir) begin
            if (imem_rsp_valid && mInAddr.size() != 0) begin
                a = mInAddr.pop_front();
                d = mInDrop.pop_front();
            end
            foreach (mInDrop[i]) mInDrop[i] = 1'b1;
            mFifoInstr.delete();
            mFifoPc.delete();
            mFetchPc = target & ~32'h3;
        end else begin
            if (expInstrValid && instrReady) begin
                a = mFifoInstr.pop_front();
                a = mFifoPc.pop_front();
            end
            if (imem_rsp_valid && mInAddr.size() != 0) begin
                a = mInAddr.pop_front();
                d = mInDrop.pop_front();
                if (!d) begin
                    mFifoInstr.push_back(memData(a));
                    mFifoPc.push_back(a);
                end
            end
            if (expReqValid && reqReady) begin
                mInAddr.push_back(mFetchPc);
                mInDrop.push_back(1'b0);
                mFetchPc = mFetchPc + 32'd4;
            end
        end
    endtask

    // advances the behavioural memory by one clock edge
    task automatic updateMemory(input int lat);
        int          due;
        logic [31:0] a;
        if (!rst_n) begin
            memQAddr.delete();
            memQDue.delete();
            lastDue = cyc;
        end else begin
            if (imem_rsp_valid) begin
                a   = memQAddr.pop_front();
                due = memQDue.pop_front();
            end
            if (imem_req_valid && imem_req_ready) begin
                due = cyc + lat;
                if (due <= lastDue) due = lastDue + 1;
                memQAddr.push_back(imem_req_addr);
                memQDue.push_back(due);
                lastDue = due;
            end
        end
    endtask

    // one full clock cycle: drive inputs, sample and check, then step model and memory
    task automatic applyStimulus(input bit rst, input bit reqReady, input bit instrReady,
                                 input bit redir, input logic [31:0] target, input int lat);
        @(negedge clk);
        rst_n          = rst;
        imem_req_ready = reqReady;
        instr_ready    = instrReady;
        redirect_valid = redir;
        redirect_pc    = target;
        if (rst && memQAddr.size() != 0 && memQDue[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memData(memQAddr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        sReqValid   = imem_req_valid;
        sReqAddr    = imem_req_addr;
        sInstrValid = instr_valid;
        sInstrPc    = instr_pc;
        checkOutput();
        updateModel(instrReady, reqReady, redir, target);
        updateMemory(lat);
        cyc++;
    endtask

    initial begin
        int          fires;
        int          nPop;
        int          badSeen;
        logic [31:0] popPc[2];
        logic [31:0] firstPc;
        logic [31:0] tgt;

        // reset release, 1-cycle memory, decoder always ready
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 1, 0, 0, 1);
        check("t1_first_req_valid", 32'(sReqValid), 32'd1);
        check("t1_first_req_addr", sReqAddr, 32'h0);
        applyStimulus(1, 1, 1, 0, 0, 1);
        check("t1_second_req_addr", sReqAddr, 32'h4);
        check("t1_no_instr_yet", 32'(sInstrValid), 32'd0);
        applyStimulus(1, 1, 1, 0, 0, 1);
        check("t1_instr0_valid", 32'(sInstrValid), 32'd1);
        check("t1_instr0_pc", sInstrPc, 32'h0);
        check("t1_credits_exhausted", 32'(sReqValid), 32'd0);
        applyStimulus(1, 1, 1, 0, 0, 1);
        check("t1_instr1_pc", sInstrPc, 32'h4);
        check("t1_third_req_addr", sReqAddr, 32'h8);
        for (int i = 0; i < 8; i++) applyStimulus(1, 1, 1, 0, 0, 1);

        // decoder stalled: exactly DEPTH requests, then drained in order
        applyStimulus(0, 0, 0, 0, 0, 1);
        fires = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 0, 0, 0, 1);
            if (sReqValid) fires++;
        end
        check("t2_req_count", 32'(fires), 32'(DEPTH));
        check("t2_req_valid_low", 32'(sReqValid), 32'd0);
        nPop = 0;
        popPc[0] = 32'hDEAD_BEEF;
        popPc[1] = 32'hDEAD_BEEF;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 1, 0, 0, 1);
            if (sInstrValid) begin
                if (nPop < 2) popPc[nPop] = sInstrPc;
                nPop++;
            end
        end
        check("t2_pop_count", 32'(nPop), 32'd2);
        check("t2_pop0_pc", popPc[0], 32'h0);
        check("t2_pop1_pc", popPc[1], 32'h4);

        // redirect with two slow reads in flight
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 3);
        applyStimulus(1, 1, 0, 0, 0, 3);
        applyStimulus(1, 1, 0, 1, 32'h100, 3);
        firstPc = 32'hFFFF_FFFF;
        badSeen = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 1, 1, 0, 0, 1);
            if (sInstrValid) begin
                if (firstPc == 32'hFFFF_FFFF) firstPc = sInstrPc;
                if (sInstrPc < 32'h10) badSeen++;
            end
        end
        check("t3_first_pc", firstPc, 32'h100);
        check("t3_wrong_path_seen", 32'(badSeen), 32'd0);

        // redirect coinciding with a response and a ready decoder
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 1);
        applyStimulus(1, 1, 1, 1, 32'h203, 1);
        check("t4_no_pop", 32'(sInstrValid), 32'd0);
        check("t4_no_req", 32'(sReqValid), 32'd0);
        applyStimulus(1, 1, 1, 0, 0, 1);
        check("t4_req_valid", 32'(sReqValid), 32'd1);
        check("t4_req_addr", sReqAddr, 32'h200);
        check("t4_fifo_flushed", 32'(sInstrValid), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 0, 0, 1);

        // memory back-pressure holds the request; redirect withdraws it
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        check("t5_hold_valid", 32'(sReqValid), 32'd1);
        check("t5_hold_addr1", sReqAddr, 32'h4);
        applyStimulus(1, 0, 0, 0, 0, 1);
        check("t5_hold_addr2", sReqAddr, 32'h4);
        applyStimulus(1, 0, 0, 1, 32'h340, 1);
        check("t5_redirect_withdraw", 32'(sReqValid), 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 1);
        check("t5_new_valid", 32'(sReqValid), 32'd1);
        check("t5_new_addr", sReqAddr, 32'h340);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 0, 0, 1);

        // one-cycle reset in the middle of traffic
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 1, 0, 0, 1);
        applyStimulus(0, 1, 1, 0, 0, 1);
        check("t6_rst_req_valid", 32'(sReqValid), 32'd0);
        check("t6_rst_instr_valid", 32'(sInstrValid), 32'd0);
        applyStimulus(1, 1, 1, 0, 0, 1);
        check("t6_req_addr", sReqAddr, RESET_PC);
        check("t6_instr_invalid1", 32'(sInstrValid), 32'd0);
        applyStimulus(1, 1, 1, 0, 0, 1);
        check("t6_instr_invalid2", 32'(sInstrValid), 32'd0);
        applyStimulus(1, 1, 1, 0, 0, 1);
        check("t6_instr_valid", 32'(sInstrValid), 32'd1);
        check("t6_instr_pc", sInstrPc, RESET_PC);

        // redirect close to the top of the address space to exercise PC wrap
        applyStimulus(1, 1, 1, 1, 32'hFFFF_FFFA, 1);
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 1, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom);
            applyStimulus($urandom_range(0, 199) != 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 15) == 0,
                          tgt,
                          $urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
